// File: rtl/sp3_uplink_aligner.sv
// Per-channel uplink word aligner: settles, checks receiver ready, issues bitslips
// until lock or give-up, and tracks lock-loss events.
module sp3_uplink_aligner #(
  parameter int N_CH          = 2,
  parameter int SETTLE_CYCLES = 64,
  parameter int LOCK_CYCLES   = 1024,
  parameter int MAX_SLIPS     = 79
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESET,
  input  logic [N_CH-1:0]   en_i,
  input  logic [N_CH-1:0]   rdy_i,
  input  logic [N_CH-1:0]   manual_slip_i,
  input  logic              clear_i,
  output logic [N_CH-1:0]   bitslip_o,
  output logic [N_CH-1:0]   locked_o,
  output logic [N_CH-1:0]   fail_o,
  output logic [8*N_CH-1:0] slip_count_o,
  output logic [8*N_CH-1:0] loss_count_o
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int RW = $clog2(LOCK_CYCLES + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RUN_LAST    = RW'(LOCK_CYCLES - 1);
  localparam logic [7:0]    SLIP_LIMIT  = 8'(MAX_SLIPS);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_SLIP   = 3'd3;
  localparam logic [2:0] ST_LOCKED = 3'd4;
  localparam logic [2:0] ST_FAIL   = 3'd5;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [2:0]    state,      state_nx;
    logic [SW-1:0] settle_cnt, settle_nx;
    logic [RW-1:0] run_cnt,    run_nx;
    logic [7:0]    slip_cnt,   slip_nx;
    logic [7:0]    loss_cnt;
    logic          loss_evt;
    logic          man_fire;
    logic          bslip_r, lock_r, fail_r;

    always_comb begin
      state_nx  = state;
      settle_nx = settle_cnt;
      run_nx    = run_cnt;
      slip_nx   = slip_cnt;
      loss_evt  = 1'b0;
      man_fire  = 1'b0;
      if (!en_i[c]) begin
        // Disable wins from any state; manual slips are only honoured when parked.
        state_nx = ST_IDLE;
        man_fire = (state == ST_IDLE) && manual_slip_i[c];
      end else begin
        case (state)
          ST_IDLE: begin
            state_nx  = ST_SETTLE;
            settle_nx = '0;
            slip_nx   = '0;
          end
          ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              state_nx = ST_CHECK;
              run_nx   = '0;
            end else begin
              settle_nx = settle_cnt + 1'b1;
            end
          end
          ST_CHECK: begin
            if (rdy_i[c]) begin
              if (run_cnt == RUN_LAST) state_nx = ST_LOCKED;
              else                     run_nx   = run_cnt + 1'b1;
            end else if (slip_cnt == SLIP_LIMIT) begin
              state_nx = ST_FAIL;
            end else begin
              state_nx = ST_SLIP;
              slip_nx  = slip_cnt + 1'b1;
            end
          end
          ST_SLIP: begin
            state_nx  = ST_SETTLE;
            settle_nx = '0;
          end
          ST_LOCKED: begin
            if (!rdy_i[c]) begin
              loss_evt  = 1'b1;
              slip_nx   = '0;
              state_nx  = ST_SETTLE;
              settle_nx = '0;
            end
          end
          ST_FAIL: state_nx = ST_FAIL;
          default: state_nx = ST_IDLE;
        endcase
      end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
        state      <= ST_IDLE;
        settle_cnt <= '0;
        run_cnt    <= '0;
        slip_cnt   <= '0;
        loss_cnt   <= '0;
        bslip_r    <= 1'b0;
        lock_r     <= 1'b0;
        fail_r     <= 1'b0;
      end else begin
        state      <= state_nx;
        settle_cnt <= settle_nx;
        run_cnt    <= run_nx;
        slip_cnt   <= slip_nx;
        bslip_r    <= (state_nx == ST_SLIP) || man_fire;
        lock_r     <= (state_nx == ST_LOCKED);
        fail_r     <= (state_nx == ST_FAIL);
        if (clear_i)                         loss_cnt <= '0;
        else if (loss_evt && loss_cnt != '1) loss_cnt <= loss_cnt + 1'b1;
      end
    end

    assign bitslip_o[c]          = bslip_r;
    assign locked_o[c]           = lock_r;
    assign fail_o[c]             = fail_r;
    assign slip_count_o[8*c +: 8] = slip_cnt;
    assign loss_count_o[8*c +: 8] = loss_cnt;
  end

endmodule

// File: tb/tb_sp3_uplink_aligner.sv
// Directed bench for sp3_uplink_aligner with two channels and short timing parameters.
module tb_sp3_uplink_aligner;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  en, rdy, man;
  logic        clr;
  logic [1:0]  bitslip, locked, fail;
  logic [15:0] slip_count, loss_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  sp3_uplink_aligner #(
    .N_CH(2), .SETTLE_CYCLES(4), .LOCK_CYCLES(8), .MAX_SLIPS(3)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .en_i          (en),
    .rdy_i         (rdy),
    .manual_slip_i (man),
    .clear_i       (clr),
    .bitslip_o     (bitslip),
    .locked_o      (locked),
    .fail_o        (fail),
    .slip_count_o  (slip_count),
    .loss_count_o  (loss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int npulse, first, last, gap_bad, other;

    rst = 1'b1; en = '0; rdy = '0; man = '0; clr = 1'b0;
    #1;
    check("rst_bitslip", bitslip, 0);
    check("rst_locked", locked, 0);
    check("rst_fail", fail, 0);
    check("rst_slip", slip_count, 0);
    check("rst_loss", loss_count, 0);
    #22 rst = 1'b0;
    step(1);

    // Channel 0 locks directly: 4 settle + 8 check cycles.
    rdy = 2'b01; en = 2'b01;
    npulse = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (bitslip != 0) npulse++;
    end
    check("a_locked_early", locked, 0);
    step(1);
    check("a_locked", locked, 2'b01);
    check("a_pulses", npulse, 0);
    check("a_slip", slip_count[7:0], 0);
    en = 2'b00;
    step(1);
    check("a_dis_locked", locked, 0);

    // Channel 0 never ready: three slips six cycles apart, then FAIL.
    rdy = 2'b00; en = 2'b01;
    npulse = 0; first = 0; last = 0; gap_bad = 0; other = 0;
    for (int k = 1; k <= 23; k++) begin
      step(1);
      if (bitslip[0]) begin
        if (npulse == 0) first = k;
        else if (k - last != 6) gap_bad++;
        last = k;
        npulse++;
      end
      if (bitslip[1] || locked[1] || fail[1]) other++;
    end
    check("b_fail_early", fail, 0);
    step(1);
    check("b_fail", fail, 2'b01);
    check("b_pulses", npulse, 3);
    check("b_first", first, 6);
    check("b_gaps", gap_bad, 0);
    check("b_slip", slip_count[7:0], 3);
    check("b_ch1_quiet", other, 0);
    check("b_ch1_slip", slip_count[15:8], 0);
    step(5);
    check("b_fail_hold", fail, 2'b01);
    en = 2'b00;
    step(1);
    check("b_dis_fail", fail, 0);
    check("b_slip_hold", slip_count[7:0], 3);

    // Channel 1 becomes ready after its second slip.
    en = 2'b10;
    npulse = 0;
    for (int k = 1; k <= 24; k++) begin
      step(1);
      if (bitslip[1]) npulse++;
      if (k == 12) begin
        check("c_slip2", bitslip, 2'b10);
        rdy = 2'b10;
      end
    end
    check("c_locked_early", locked, 0);
    step(1);
    check("c_locked", locked, 2'b10);
    check("c_pulses", npulse, 2);
    check("c_slip", slip_count[15:8], 2);
    rdy = 2'b00;
    step(1);
    rdy = 2'b10;
    check("c_loss", loss_count[15:8], 1);
    check("c_unlocked", locked, 0);
    check("c_slip_clr", slip_count[15:8], 0);
    npulse = 0;
    for (int k = 1; k <= 11; k++) begin
      step(1);
      if (bitslip != 0) npulse++;
    end
    check("c_relock_early", locked, 0);
    step(1);
    check("c_relock", locked, 2'b10);
    check("c_relock_pulses", npulse, 0);

    // Manual slips: honoured only when idle and disabled.
    en = 2'b00; rdy = 2'b00;
    step(1);
    man = 2'b11;
    step(1);
    man = 2'b00;
    check("d_manual", bitslip, 2'b11);
    step(1);
    check("d_manual_end", bitslip, 0);
    en = 2'b11; man = 2'b11;
    step(1);
    man = 2'b00;
    check("d_manual_en", bitslip, 0);
    step(1);
    check("d_manual_en2", bitslip, 0);
    en = 2'b00;
    step(1);

    // Asynchronous reset while channel 0 is slipping.
    en = 2'b01; rdy = 2'b00;
    step(6);
    check("e_in_slip", bitslip, 2'b01);
    #2 rst = 1'b1;
    #1;
    check("e_rst_bitslip", bitslip, 0);
    check("e_rst_slip", slip_count, 0);
    check("e_rst_loss", loss_count, 0);
    en = 2'b00;
    #1 rst = 1'b0;
    step(1);
    check("e_post_bitslip", bitslip, 0);
    step(1);
    check("e_post_bitslip2", bitslip, 0);

    // Loss counter saturation and clear on channel 1.
    en = 2'b10; rdy = 2'b10;
    step(13);
    check("f_locked", locked, 2'b10);
    for (int i = 0; i < 255; i++) begin
      rdy = 2'b00; step(1);
      rdy = 2'b10; step(12);
    end
    check("f_loss255", loss_count[15:8], 255);
    check("f_relocked", locked, 2'b10);
    rdy = 2'b00; step(1);
    rdy = 2'b10; step(12);
    check("f_loss_sat", loss_count[15:8], 255);
    rdy = 2'b00; clr = 1'b1; step(1);
    rdy = 2'b10; clr = 1'b0;
    check("f_clr_with_loss", loss_count[15:8], 0);
    step(12);
    rdy = 2'b00; step(1);
    rdy = 2'b10;
    check("f_loss_again", loss_count[15:8], 1);
    clr = 1'b1; step(1);
    clr = 1'b0;
    check("f_clear", loss_count[15:8], 0);
    check("f_ch0_loss", loss_count[7:0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sp3_uplink_aligner.md
SP3_UPLINK_ALIGNER -- requirements
Module: sp3_uplink_aligner

Interface
REQ-001 Parameter N_CH, default 2: number of independent uplink channels, 1..8.
REQ-002 Parameter SETTLE_CYCLES, default 64: wait after enable/slip before sampling ready, >=1.
REQ-003 Parameter LOCK_CYCLES, default 1024: consecutive ready cycles required to declare lock, >=1.
REQ-004 Parameter MAX_SLIPS, default 79: bitslips attempted before failure, 1..255.
REQ-005 S_AXI_ACLK  in  1  sole clock; all logic on rising edge.
REQ-006 S_AXI_ARESET  in  1  asynchronous, active-high reset.
REQ-007 en_i  in  N_CH  per-channel auto-align enable, level.
REQ-008 rdy_i  in  N_CH  per-channel uplink ready, already synchronous to S_AXI_ACLK.
REQ-009 manual_slip_i  in  N_CH  per-channel single-cycle manual bitslip request.
REQ-010 clear_i  in  1  single-cycle clear of all loss counters.
REQ-011 bitslip_o  out  N_CH  per-channel bitslip pulse to the receiver.
REQ-012 locked_o  out  N_CH  channel in LOCKED.
REQ-013 fail_o  out  N_CH  channel in FAIL.
REQ-014 slip_count_o  out  8*N_CH  slips issued in current attempt, channel c at [8c+7:8c].
REQ-015 loss_count_o  out  8*N_CH  lock-loss events since reset/clear, same packing.

Function
REQ-016 Each channel SHALL run an independent FSM: IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL; channels share no state except clear_i.
REQ-017 IDLE: en_i=1 -> SETTLE, slip_count cleared to 0.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then CHECK with run counter 0; rdy_i ignored.
REQ-019 CHECK: rdy_i=1 increments run counter; on the LOCK_CYCLES-th consecutive high cycle -> LOCKED next edge.
REQ-020 CHECK: rdy_i=0 -> FAIL if slip_count==MAX_SLIPS, else SLIP.
REQ-021 SLIP SHALL last one cycle, assert bitslip_o for exactly that cycle (registered), increment slip_count, then SETTLE.
REQ-022 LOCKED: locked_o=1; rdy_i=0 -> loss_count+1 (saturating at 255), slip_count cleared, -> SETTLE (no slip).
REQ-023 FAIL: fail_o=1, held until en_i=0.
REQ-024 en_i=0 in any state -> IDLE next edge; bitslip_o forced 0 that cycle; slip_count holds its value.
REQ-025 manual_slip_i SHALL produce a one-cycle bitslip_o on the next cycle only when the channel is IDLE and en_i=0; otherwise ignored.
REQ-026 clear_i SHALL zero all loss_count; clear coinciding with a loss event yields 0.
REQ-027 locked_o, fail_o, bitslip_o SHALL be registered, mutually exclusive per channel.
REQ-028 Counter widths: SETTLE/CHECK counters sized $clog2(max+1); no wrap.

Reset
REQ-029 S_AXI_ARESET=1 SHALL immediately force all FSMs to IDLE and all outputs and counters to 0, regardless of clock.
REQ-030 Deassertion: first transition evaluated on the first rising edge with reset low.
REQ-031 Reset mid-SLIP SHALL truncate bitslip_o immediately; no pulse after release unless re-requested.

Verification (N_CH=2, SETTLE_CYCLES=4, LOCK_CYCLES=8, MAX_SLIPS=3)
REQ-032 rdy_i[0]=1 constant, en_i[0] rises -> locked_o[0]=1 after 4 SETTLE + 8 CHECK cycles; zero bitslip pulses; slip_count=0.
REQ-033 rdy_i[0]=0 constant, en_i[0] rises -> exactly 3 bitslip_o[0] pulses 6 cycles apart, then fail_o[0]=1, slip_count=3; channel 1 undisturbed.
REQ-034 rdy_i[1] goes high only after 2nd slip -> locked_o[1]=1, slip_count=2; then drop rdy_i[1] one cycle -> loss_count=1, re-lock with no slip.
REQ-035 en_i=0, manual_slip_i=2'b11 one cycle -> bitslip_o=2'b11 for one cycle next edge; same with en_i=1 -> no pulse.
REQ-036 Reset asserted mid-SLIP and asynchronously between edges -> outputs 0 before next edge; 255 losses then one more -> loss_count stays 255; clear_i -> 0.
